tx_fcs_rcal: RTL



---
 rtl/tx_fcs_rcal_pkg.sv | 40 ++++
 rtl/crc32_d64.sv | 21 ++
 rtl/tx_fcs_rcal.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/tx_fcs_rcal_pkg.sv
// Shared XGMII/Ethernet constants, pipeline tag type and CRC-32 byte step
// for the transmit FCS recalculation stage.
package tx_fcs_rcal_pkg;

    localparam logic [63:0] XGMII_IDLE_WORD = 64'h0707070707070707;
    localparam logic [7:0]  XGMII_IDLE_CTRL = 8'hFF;
    localparam logic [7:0]  XGMII_START     = 8'hFB;
    localparam logic [7:0]  XGMII_TERM      = 8'hFD;
    localparam logic [7:0]  XGMII_ERR       = 8'hFE;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [31:0] CRC32_POLY_R    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StBypass
    } fcs_state_e;

    // Per-word classification, computed on input and carried through s1/s2.
    typedef struct packed {
        logic       sop;        // start word: reinitialise the CRC
        logic       pay;        // payload word of a frame still eligible for recalculation
        logic       last;       // word carries the terminate character
        logic       ok;         // terminate word of a clean, non-runt frame
        logic [2:0] term_lane;
    } word_tag_t;

    localparam word_tag_t TAG_IDLE = '0;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_R) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d64.sv
// Combinational CRC-32 update over lanes 0..nbytes-1 of a 64-bit word
// (reflected polynomial, result not complemented).
module crc32_d64
    import tx_fcs_rcal_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                crc_out = crc32_byte(crc_out, data[8*i +: 8]);
            end
        end
    end

endmodule

// File: rtl/tx_fcs_rcal.sv
// Transmit FCS recalculation: recomputes CRC-32 over each XGMII frame and
// overwrites the four trailing FCS octets, with a fixed three-word latency.
module tx_fcs_rcal
    import tx_fcs_rcal_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 3
) (
    input  logic        tx_clk,
    input  logic        tx_rst_n,
    input  logic        tx_clk_en_i,
    input  logic        fcs_rcal_en_i,
    input  logic [63:0] txd_i,
    input  logic [7:0]  txc_i,
    output logic [63:0] txd_o,
    output logic [7:0]  txc_o,
    output logic        fcs_rcal_done_o
);

    localparam int unsigned IdxS3 = PIPE_STAGES - 1;

    fcs_state_e   state_q, state_d;
    logic [10:0]  cnt_q, cnt_d;
    word_tag_t    tag_in, tag_s1_q, tag_s2_q;
    logic [63:0]  pd_q [PIPE_STAGES];
    logic [7:0]   pc_q [PIPE_STAGES];
    logic [31:0]  crc_q, crc_d, crc_out, fcs;
    logic [127:0] repl_q, repl_d;
    logic [15:0]  rmask_q, rmask_d;
    logic [1:0]   done_q, done_d;

    logic         is_start, term_found, bad_ctrl;
    logic [2:0]   term_lane;
    logic         case_a, case_b;
    logic [3:0]   nbytes;
    logic [4:0]   tpos;
    logic [3:0]   fcs_pos;

    // Input word scan: first terminate lane and any other control before it.
    always_comb begin
        is_start   = txc_i[0] && (txd_i[7:0] == XGMII_START);
        term_found = 1'b0;
        term_lane  = 3'd0;
        bad_ctrl   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!term_found && txc_i[i]) begin
                if (txd_i[8*i +: 8] == XGMII_TERM) begin
                    term_found = 1'b1;
                    term_lane  = 3'(i);
                end else begin
                    bad_ctrl = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_in  = TAG_IDLE;
        if (is_start) begin
            // A start word always opens a new frame, abandoning any open one.
            state_d    = fcs_rcal_en_i ? StCalc : StBypass;
            cnt_d      = 11'd0;
            tag_in.sop = 1'b1;
        end else begin
            case (state_q)
                StCalc: begin
                    tag_in.pay       = !bad_ctrl;
                    tag_in.last      = term_found;
                    tag_in.term_lane = term_lane;
                    // Octets before T minus the four FCS octets must leave >= 1 payload octet.
                    tag_in.ok = term_found && !bad_ctrl &&
                                (({1'b0, cnt_q} + {9'd0, term_lane}) >= 12'd5);
                    if (term_found) begin
                        state_d = StIdle;
                    end else if (bad_ctrl) begin
                        state_d = StBypass;
                    end else begin
                        cnt_d = (cnt_q > 11'd2039) ? 11'h7FF : cnt_q + 11'd8;
                    end
                end
                StBypass: begin
                    if (term_found) begin
                        state_d = StIdle;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lookahead: T in s1 at lane k<4 or T in s2 at lane k>=4 completes the CRC on s2.
    always_comb begin
        case_a = tag_s1_q.ok && !tag_s1_q.term_lane[2];
        case_b = tag_s2_q.ok && tag_s2_q.term_lane[2];
        nbytes = 4'd0;
        tpos   = 5'd0;
        if (case_a) begin
            nbytes = {1'b0, tag_s1_q.term_lane} + 4'd4;
            tpos   = 5'd8 + {2'b0, tag_s1_q.term_lane};
        end else if (case_b) begin
            nbytes = {1'b0, tag_s2_q.term_lane} - 4'd4;
            tpos   = {2'b0, tag_s2_q.term_lane};
        end else if (tag_s2_q.pay && !tag_s2_q.last) begin
            nbytes = 4'd8;
        end
    end

    crc32_d64 u_crc32_d64 (
        .crc_in  (crc_q),
        .data    (pd_q[1]),
        .nbytes  (nbytes),
        .crc_out (crc_out)
    );

    assign fcs   = ~crc_out;
    assign crc_d = (tag_s2_q.sop || case_a || case_b) ? CRC32_INIT : crc_out;

    // Replacement window spans the word entering s3 (bits 63:0) and the one after it.
    always_comb begin
        repl_d  = {64'h0, repl_q[127:64]};
        rmask_d = {8'h0, rmask_q[15:8]};
        done_d  = {1'b0, done_q[1]};
        fcs_pos = 4'd0;
        if (case_a || case_b) begin
            repl_d  = '0;
            rmask_d = '0;
            for (int j = 0; j < 4; j++) begin
                fcs_pos                         = 4'(tpos - 5'd4 + 5'(j));
                repl_d[{fcs_pos, 3'b000} +: 8]  = fcs[8*j +: 8];
                rmask_d[fcs_pos]                = 1'b1;
            end
            done_d = (tpos > 5'd8) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            for (int i = 0; i < int'(PIPE_STAGES); i++) begin
                pd_q[i] <= XGMII_IDLE_WORD;
                pc_q[i] <= XGMII_IDLE_CTRL;
            end
            state_q  <= StIdle;
            cnt_q    <= 11'd0;
            tag_s1_q <= TAG_IDLE;
            tag_s2_q <= TAG_IDLE;
            crc_q    <= CRC32_INIT;
            repl_q   <= '0;
            rmask_q  <= '0;
            done_q   <= 2'b00;
        end else if (tx_clk_en_i) begin
            pd_q[0] <= txd_i;
            pc_q[0] <= txc_i;
            for (int i = 1; i < int'(PIPE_STAGES); i++) begin
                pd_q[i] <= pd_q[i-1];
                pc_q[i] <= pc_q[i-1];
            end
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_s1_q <= tag_in;
            tag_s2_q <= tag_s1_q;
            crc_q    <= crc_d;
            repl_q   <= repl_d;
            rmask_q  <= rmask_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        txd_o = pd_q[IdxS3];
        for (int i = 0; i < 8; i++) begin
            if (rmask_q[i]) begin
                txd_o[8*i +: 8] = repl_q[8*i +: 8];
            end
        end
    end

    assign txc_o           = pc_q[IdxS3];
    assign fcs_rcal_done_o = done_q[0];

endmodule
